// File: rtl/fifo_unpacker_pkg.sv
// rtl/fifo_unpacker_pkg.sv - shared FSM encoding and width helper for the FIFO read side
package fifo_unpacker_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Minimum bit count to index 'value' items; never less than 1.
  function automatic int clogb2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_unpacker.sv
// rtl/fifo_unpacker.sv - splits DW-bit FIFO words into OW-bit slices; FIFO_UNPACKER_LSB_FIRST_EN selects LSB-first order
module fifo_unpacker
  import fifo_unpacker_pkg::*;
#(
  parameter int DW = 32,
  parameter int OW = 16
) (
  input  logic          clk,
  input  logic          clk7_en,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] fifo_out,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  output logic [OW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last
);

  localparam int R  = DW / OW;
  localparam int IW = clogb2(R);
  localparam logic [IW-1:0] IDX_LAST = IW'(R - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] word_q, word_d;
  logic [DW-1:0] shifted;
  logic          send;
  logic          handshake;
  logic          rd_en;

  assign send      = (state_q == ST_SEND);
  assign handshake = clk7_en && send && out_ready;

  // Shift the selected slice to a fixed position rather than using a variable part-select.
  always_comb begin
    shifted = '0;
`ifdef FIFO_UNPACKER_LSB_FIRST_EN
    shifted = word_q >> (int'(idx_q) * OW);
`else
    shifted = word_q << (int'(idx_q) * OW);
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    rd_en   = 1'b0;
    if (clk7_en) begin
      if (flush) begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (!fifo_empty) begin
              rd_en   = 1'b1;
              word_d  = fifo_out;
              idx_d   = '0;
              state_d = ST_SEND;
            end
          end
          ST_SEND: begin
            if (handshake) begin
              if (idx_q != IDX_LAST) begin
                idx_d = idx_q + IW'(1);
              end else if (!fifo_empty) begin
                // Reload straight from the show-ahead FIFO so words stream without a bubble.
                rd_en  = 1'b1;
                word_d = fifo_out;
                idx_d  = '0;
              end else begin
                state_d = ST_IDLE;
                idx_d   = '0;
              end
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

  // Outputs are forced quiet while reset is held, even before the first reset edge.
  assign fifo_rd_en = rd_en && !rst;
  assign out_valid  = send && !rst;
  assign out_last   = out_valid && (idx_q == IDX_LAST);
`ifdef FIFO_UNPACKER_LSB_FIRST_EN
  assign out_data   = rst ? '0 : shifted[OW-1:0];
`else
  assign out_data   = rst ? '0 : shifted[DW-1:DW-OW];
`endif

endmodule

// File: doc/fifo_unpacker.md
FIFO_UNPACKER -- requirements
Module: fifo_unpacker

Interface
REQ-001 Parameter: DW, 32, FIFO read-word width in bits.
REQ-002 Parameter: OW, 16, output slice width in bits; DW SHALL be an integer multiple of OW, with R = DW/OW >= 2.
REQ-003 Port: clk  input  1  system clock.
REQ-004 Port: clk7_en  input  1  7MHz clock enable; all state advances only on clk edges where clk7_en=1.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: flush  input  1  synchronous discard of the held word.
REQ-007 Port: fifo_out  input  DW  FIFO show-ahead read data, valid whenever fifo_empty=0.
REQ-008 Port: fifo_empty  input  1  FIFO empty flag.
REQ-009 Port: fifo_rd_en  output  1  FIFO pop strobe, combinational.
REQ-010 Port: out_data  output  OW  current output slice.
REQ-011 Port: out_valid  output  1  out_data is valid.
REQ-012 Port: out_ready  input  1  consumer accepts the slice.
REQ-013 Port: out_last  output  1  current slice is the final slice of its word.

Function
REQ-014 The block SHALL be a 2-state FSM, IDLE and SEND, with a DW-bit word register and a slice index idx of width clog2(R).
REQ-015 IDLE with fifo_empty=0 and clk7_en=1: fifo_rd_en=1, word register SHALL capture fifo_out, idx<=0, next state SEND.
REQ-016 A handshake SHALL occur on a clk7_en=1 edge with out_valid=1 and out_ready=1.
REQ-017 SEND: out_valid SHALL be 1; out_data SHALL be slice idx of the word; slice 0 is bits [DW-1:DW-OW] (MSB first).
REQ-018 A handshake with idx<R-1 SHALL increment idx and SHALL NOT pop the FIFO.
REQ-019 A handshake with idx=R-1 and fifo_empty=0 SHALL assert fifo_rd_en, load fifo_out, set idx<=0, and stay in SEND, with no bubble cycle.
REQ-020 A handshake with idx=R-1 and fifo_empty=1 SHALL return to IDLE.
REQ-021 out_last SHALL equal (state==SEND && idx==R-1).
REQ-022 out_data, out_valid, and out_last SHALL be stable while out_valid=1 and no handshake occurs, including on clk7_en=0 cycles.
REQ-023 fifo_rd_en SHALL be asserted only when clk7_en=1 and fifo_empty=0; it is never asserted on an empty FIFO.
REQ-024 Latency: the first slice SHALL be valid one clk7_en cycle after fifo_empty falls while in IDLE.
REQ-025 flush=1 with clk7_en=1 SHALL force IDLE and idx<=0, and SHALL NOT pop the FIFO that cycle; flush takes priority over handshake and load.
REQ-026 A handshake coinciding with flush SHALL still count as accepted by the consumer; the remaining slices are dropped.

Reset
REQ-027 rst=1 on any clk edge, regardless of clk7_en, SHALL set state=IDLE, idx=0, and word register=0.
REQ-028 During reset: out_valid=0, out_last=0, out_data=0, fifo_rd_en=0.
REQ-029 Reset mid-word SHALL discard remaining slices; no partial word is resumed.

Configuration
REQ-030 Macro FIFO_UNPACKER_LSB_FIRST_EN: when defined, slice 0 SHALL be bits [OW-1:0] and slices ascend (little-endian).
REQ-031 When FIFO_UNPACKER_LSB_FIRST_EN is undefined, MSB-first ordering per REQ-017 applies; no other behaviour differs.

Structure
REQ-032 The FSM state encoding (IDLE=0, SEND=1) and the CLogB2 width function SHALL live in a shared package with the FIFO.
REQ-033 The block is a single module with no sub-modules; it is intended to sit directly on the sync_fifo read side.

Verification
REQ-034 Reset, then push 0xDEADBEEF with out_ready=1 -> out_data 0xDEAD (out_last=0), then 0xBEEF (out_last=1), then out_valid=0; exactly one fifo_rd_en pulse.
REQ-035 Push 0x11112222 and 0x33334444 back-to-back with out_ready=1 -> slices 0x1111, 0x2222, 0x3333, 0x4444 on consecutive clk7_en cycles with no gap.
REQ-036 out_ready=0 for 5 clk7_en cycles with 0xCAFEF00D loaded -> out_data holds 0xCAFE and fifo_rd_en stays 0.
REQ-037 flush after slice 0xDEAD is accepted -> 0xBEEF never appears; the next pushed word 0x12345678 emits 0x1234 first.
REQ-038 Build with FIFO_UNPACKER_LSB_FIRST_EN and push 0xDEADBEEF -> 0xBEEF, then 0xDEAD with out_last=1.
REQ-039 Drive clk7_en=1 only one clk in 4 -> same slice order as REQ-034; outputs change only on enabled edges; FIFO is never underflowed.
